// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two caches, the block arbiter and the cache_data_transfer unit.
// The slave modport is the arbiter's view; master is the surrounding caches/transfer unit.
interface cache_mem_arbiter_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 1024
);
  logic                   ic_read_start;
  logic [ADDR_WIDTH-1:0]  ic_addr;
  logic [BLOCK_WIDTH-1:0] ic_data_block;
  logic                   ic_done;

  logic                   dc_read_start;
  logic                   dc_write_start;
  logic [ADDR_WIDTH-1:0]  dc_addr;
  logic [BLOCK_WIDTH-1:0] dc_wr_block;
  logic [BLOCK_WIDTH-1:0] dc_data_block;
  logic                   dc_done;

  logic                   start_read;
  logic                   start_write;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [BLOCK_WIDTH-1:0] wr_block;
  logic [BLOCK_WIDTH-1:0] rd_block;
  logic                   count_done;

  modport slave (
    input  ic_read_start, ic_addr, dc_read_start, dc_write_start, dc_addr, dc_wr_block,
           rd_block, count_done,
    output ic_data_block, ic_done, dc_data_block, dc_done, start_read, start_write,
           addr, wr_block
  );

  modport master (
    output ic_read_start, ic_addr, dc_read_start, dc_write_start, dc_addr, dc_wr_block,
           rd_block, count_done,
    input  ic_data_block, ic_done, dc_data_block, dc_done, start_read, start_write,
           addr, wr_block
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Grants one I-cache or D-cache block transaction at a time to the shared transfer unit.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: D over I).
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

  state_t                 state;
  logic                   start_read_q;
  logic                   start_write_q;
  logic                   ic_done_q;
  logic                   dc_done_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BLOCK_WIDTH-1:0] wr_block_q;
  logic [BLOCK_WIDTH-1:0] ic_block_q;
  logic [BLOCK_WIDTH-1:0] dc_block_q;

  logic dc_req;
  logic ic_req;
  logic grant_d;
  logic dc_is_write;

  assign dc_req      = bus.dc_read_start | bus.dc_write_start;
  assign ic_req      = bus.ic_read_start;
  assign dc_is_write = bus.dc_write_start;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // last_grant: 0 = I-cache was granted last, 1 = D-cache was granted last
  logic last_grant;
  assign grant_d = dc_req & (~ic_req | ~last_grant);
`else
  assign grant_d = dc_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      start_read_q  <= 1'b0;
      start_write_q <= 1'b0;
      ic_done_q     <= 1'b0;
      dc_done_q     <= 1'b0;
      addr_q        <= '0;
      wr_block_q    <= '0;
      ic_block_q    <= '0;
      dc_block_q    <= '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_grant    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            addr_q        <= bus.dc_addr;
            start_write_q <= dc_is_write;
            start_read_q  <= ~dc_is_write;
            if (dc_is_write) wr_block_q <= bus.dc_wr_block;
            state         <= BUSY_D;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_grant    <= 1'b1;
`endif
          end else if (ic_req) begin
            addr_q        <= bus.ic_addr;
            start_write_q <= 1'b0;
            start_read_q  <= 1'b1;
            state         <= BUSY_I;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_grant    <= 1'b0;
`endif
          end
        end
        // start_write_q doubles as the latched op for the whole transaction
        BUSY_I, BUSY_D: begin
          if (bus.count_done) begin
            start_read_q  <= 1'b0;
            start_write_q <= 1'b0;
            if (state == BUSY_I) begin
              ic_block_q <= bus.rd_block;
              ic_done_q  <= 1'b1;
              state      <= DONE_I;
            end else begin
              if (!start_write_q) dc_block_q <= bus.rd_block;
              dc_done_q  <= 1'b1;
              state      <= DONE_D;
            end
          end
        end
        DONE_I, DONE_D: begin
          ic_done_q <= 1'b0;
          dc_done_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_read    = start_read_q;
  assign bus.start_write   = start_write_q;
  assign bus.addr          = addr_q;
  assign bus.wr_block      = wr_block_q;
  assign bus.ic_data_block = ic_block_q;
  assign bus.dc_data_block = dc_block_q;
  assign bus.ic_done       = ic_done_q;
  assign bus.dc_done       = dc_done_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter; the transfer unit is played by the bench.
// Expectations follow the default build unless CACHE_ARB_ROUND_ROBIN_EN is defined.
module tb_cache_mem_arbiter;

  localparam int AW = 64;
  localparam int BW = 1024;
  typedef logic [BW-1:0] block_t;
  typedef logic [AW-1:0] addr_t;

  logic clk;
  logic rst_n;
  int   check_count;
  int   fail_count;

  block_t exp_ic_blk;
  block_t exp_dc_blk;
  block_t exp_wblk;

  cache_mem_arbiter_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus ();

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input block_t observed, input block_t expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, want %0h (low 192 bits)", tag, observed[191:0],
               expected[191:0]);
    end
  endtask

  task automatic applyStimulus(input logic ic_rd, input addr_t ic_a, input logic dc_rd,
                               input logic dc_wr, input addr_t dc_a, input block_t dc_blk);
    bus.ic_read_start  = ic_rd;
    bus.ic_addr        = ic_a;
    bus.dc_read_start  = dc_rd;
    bus.dc_write_start = dc_wr;
    bus.dc_addr        = dc_a;
    bus.dc_wr_block    = dc_blk;
  endtask

  // Plays the transfer unit for one granted transaction and checks grant, stability and completion.
  task automatic serve_one(input string tag, input logic exp_d, input logic exp_wr,
                           input addr_t exp_addr, input block_t rdata, input int busy);
    int waited;
    waited = 0;
    while (!(bus.start_read || bus.start_write) && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput({tag, ":granted"}, block_t'(waited < 20), block_t'(1));
    checkOutput({tag, ":start_write"}, block_t'(bus.start_write), block_t'(exp_wr));
    checkOutput({tag, ":start_read"}, block_t'(bus.start_read), block_t'(!exp_wr));
    checkOutput({tag, ":addr"}, block_t'(bus.addr), block_t'(exp_addr));
    checkOutput({tag, ":wr_block"}, bus.wr_block, exp_wblk);
    for (int b = 0; b < busy; b++) begin
      if (exp_d) bus.dc_addr = ~bus.dc_addr;
      else       bus.ic_addr = ~bus.ic_addr;
      if (exp_d && exp_wr) bus.dc_wr_block = ~bus.dc_wr_block;
      tick();
      checkOutput({tag, ":busy_start"}, block_t'({bus.start_write, bus.start_read}),
                  block_t'({exp_wr, !exp_wr}));
      checkOutput({tag, ":busy_addr"}, block_t'(bus.addr), block_t'(exp_addr));
      checkOutput({tag, ":busy_wr_block"}, bus.wr_block, exp_wblk);
    end
    bus.rd_block   = rdata;
    bus.count_done = 1'b1;
    tick();
    bus.count_done = 1'b0;
    bus.rd_block   = ~rdata;
    if (!exp_wr) begin
      if (exp_d) exp_dc_blk = rdata;
      else       exp_ic_blk = rdata;
    end
    checkOutput({tag, ":ic_done"}, block_t'(bus.ic_done), block_t'(!exp_d));
    checkOutput({tag, ":dc_done"}, block_t'(bus.dc_done), block_t'(exp_d));
    checkOutput({tag, ":start_dropped"}, block_t'({bus.start_write, bus.start_read}), '0);
    checkOutput({tag, ":ic_data_block"}, bus.ic_data_block, exp_ic_blk);
    checkOutput({tag, ":dc_data_block"}, bus.dc_data_block, exp_dc_blk);
    if (exp_d) begin
      bus.dc_read_start  = 1'b0;
      bus.dc_write_start = 1'b0;
    end else begin
      bus.ic_read_start = 1'b0;
    end
    tick();
    checkOutput({tag, ":done_one_cycle"}, block_t'({bus.ic_done, bus.dc_done}), '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    block_t incr_blk;
    block_t a5_blk;
    logic   saw_activity;

    check_count = 0;
    fail_count  = 0;
    exp_ic_blk  = '0;
    exp_dc_blk  = '0;
    exp_wblk    = '0;
    for (int k = 0; k < BW / 8; k++) incr_blk[k*8 +: 8] = 8'(k);
    a5_blk = {(BW/8){8'hA5}};

    rst_n          = 1'b0;
    bus.rd_block   = '0;
    bus.count_done = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Reset, then ten quiet cycles plus a stray count_done that must be ignored.
    #3;
    checkOutput("reset:start", block_t'({bus.start_write, bus.start_read}), '0);
    checkOutput("reset:addr", block_t'(bus.addr), '0);
    checkOutput("reset:blocks", bus.ic_data_block | bus.dc_data_block | bus.wr_block, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    saw_activity = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.count_done = (c == 4);
      tick();
      saw_activity |= bus.ic_done | bus.dc_done | bus.start_read | bus.start_write;
    end
    bus.count_done = 1'b0;
    checkOutput("idle:no_activity", block_t'(saw_activity), '0);
    checkOutput("idle:blocks", bus.ic_data_block | bus.dc_data_block, '0);

    // I-cache read at 0x1000, count_done in cycle 5, done in cycle 6.
    applyStimulus(1'b1, 64'h1000, 1'b0, 1'b0, '0, '0);
    tick();
    serve_one("ic_read", 1'b0, 1'b0, 64'h1000, a5_blk, 4);

    // D-cache write-back; the input block is scrambled while busy.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 64'h2040, incr_blk);
    exp_wblk = incr_blk;
    tick();
    serve_one("dc_write", 1'b1, 1'b1, 64'h2040, {(BW/8){8'h5A}}, 2);

    // Simultaneous I and D reads, two rounds: D then I each round.
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b1, 64'h100, 1'b1, 1'b0, 64'h200, '0);
      tick();
      serve_one("sim_d", 1'b1, 1'b0, 64'h200, {(BW/8){8'(8'h30 + r)}}, 1);
      serve_one("sim_i", 1'b0, 1'b0, 64'h100, {(BW/8){8'(8'h40 + r)}}, 1);
    end

    // D read and write both high: the write wins.
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 64'h400, ~incr_blk);
    exp_wblk = ~incr_blk;
    tick();
    serve_one("dc_rd_wr", 1'b1, 1'b1, 64'h400, {(BW/8){8'h77}}, 1);

    // D alone, then both: round-robin now favours I, fixed priority still picks D.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 64'h500, '0);
    tick();
    serve_one("d_alone", 1'b1, 1'b0, 64'h500, {(BW/8){8'h11}}, 1);
    applyStimulus(1'b1, 64'h600, 1'b1, 1'b0, 64'h700, '0);
    tick();
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    serve_one("rr_first", 1'b0, 1'b0, 64'h600, {(BW/8){8'h22}}, 1);
    serve_one("rr_second", 1'b1, 1'b0, 64'h700, {(BW/8){8'h33}}, 1);
`else
    serve_one("fp_first", 1'b1, 1'b0, 64'h700, {(BW/8){8'h22}}, 1);
    serve_one("fp_second", 1'b0, 1'b0, 64'h600, {(BW/8){8'h33}}, 1);
`endif

    // Reset in the middle of a D read, then a clean retry at 0x300.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 64'h280, '0);
    tick();
    tick();
    checkOutput("midrst:busy", block_t'(bus.start_read), block_t'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst:start_async", block_t'({bus.start_write, bus.start_read}), '0);
    checkOutput("midrst:addr", block_t'(bus.addr), '0);
    checkOutput("midrst:blocks", bus.ic_data_block | bus.dc_data_block | bus.wr_block, '0);
    exp_ic_blk = '0;
    exp_dc_blk = '0;
    exp_wblk   = '0;
    bus.dc_read_start = 1'b0;
    bus.count_done    = 1'b1;
    tick();
    bus.count_done = 1'b0;
    checkOutput("midrst:no_done", block_t'({bus.ic_done, bus.dc_done}), '0);
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 64'h300, '0);
    tick();
    serve_one("after_rst", 1'b1, 1'b0, 64'h300, {(BW/8){8'hC3}}, 2);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
